// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-port memory arbiter: fetch port (a), data port (b) and downstream pmem port.
// slave is the arbiter's view; master is the datapath plus the physical memory.
interface mem_arbiter_if;
  logic        mem_read_a;
  logic [15:0] mem_address_a;
  logic        mem_resp_a;
  logic [15:0] mem_rdata_a;

  logic        mem_read_b;
  logic        mem_write_b;
  logic [1:0]  mem_wmask_b;
  logic [15:0] mem_address_b;
  logic [15:0] mem_wdata_b;
  logic        mem_resp_b;
  logic [15:0] mem_rdata_b;

  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  modport slave (
    input  mem_read_a, mem_address_a,
    output mem_resp_a, mem_rdata_a,
    input  mem_read_b, mem_write_b, mem_wmask_b, mem_address_b, mem_wdata_b,
    output mem_resp_b, mem_rdata_b,
    output pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output mem_read_a, mem_address_a,
    input  mem_resp_a, mem_rdata_a,
    output mem_read_b, mem_write_b, mem_wmask_b, mem_address_b, mem_wdata_b,
    input  mem_resp_b, mem_rdata_b,
    input  pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-to-one memory arbiter: data port b wins contention, with a bounded b-streak so fetch (a)
// is never starved. The granted request is latched so pmem_* stays stable for the transaction.
module mem_arbiter #(
  parameter int MAX_B_STREAK = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          busy
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_A = 2'd1;
  localparam logic [1:0] SERVE_B = 2'd2;
  localparam logic [2:0] MAX_S   = 3'(MAX_B_STREAK);

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  wmask;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  logic [1:0] state;
  logic [2:0] streak;
  req_t       lat;
  logic       req_a, req_b, grant_a, grant_b;

  assign req_a   = bus.mem_read_a;
  assign req_b   = bus.mem_read_b | bus.mem_write_b;
  assign grant_a = req_a & (~req_b | (streak >= MAX_S));
  assign grant_b = req_b & ~grant_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      streak <= 3'd0;
      lat    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a) begin
            state  <= SERVE_A;
            streak <= 3'd0;
            lat    <= '{rd: 1'b1, wr: 1'b0, wmask: 2'b11, addr: bus.mem_address_a, wdata: 16'h0};
          end else if (grant_b) begin
            state  <= SERVE_B;
            // Saturating; only counts b grants that made a pending fetch wait.
            streak <= req_a ? ((streak < MAX_S) ? streak + 3'd1 : streak) : 3'd0;
            lat    <= '{rd: bus.mem_read_b & ~bus.mem_write_b, wr: bus.mem_write_b,
                        wmask: bus.mem_wmask_b, addr: bus.mem_address_b, wdata: bus.mem_wdata_b};
          end
        end
        SERVE_A, SERVE_B: begin
          // Always pass through IDLE: the requester still holds its request during the resp cycle.
          if (bus.pmem_resp) begin
            state  <= IDLE;
            lat.rd <= 1'b0;
            lat.wr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read    = lat.rd;
  assign bus.pmem_write   = lat.wr;
  assign bus.pmem_wmask   = lat.wmask;
  assign bus.pmem_address = lat.addr;
  assign bus.pmem_wdata   = lat.wdata;

  assign bus.mem_resp_a  = (state == SERVE_A) & bus.pmem_resp;
  assign bus.mem_resp_b  = (state == SERVE_B) & bus.pmem_resp;
  assign bus.mem_rdata_a = bus.pmem_rdata;
  assign bus.mem_rdata_b = bus.pmem_rdata;
  assign busy            = (state != IDLE);
endmodule
